// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: issues one vector FP op lane-by-lane through a shared FP unit,
// stalling the pipeline and driving registered writeback (scalar for vsum reductions).
module vector_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int LIDX_W = $clog2(LANES)
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [3:0]        alucontrol_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              fu_valid_o,
    input  logic              fu_ready_i,
    output logic [3:0]        fu_op_o,
    output logic [LIDX_W-1:0] fu_lane_o,
    output logic              fu_use_acc_o,
    output logic [DATA_W-1:0] acc_o,
    input  logic              fu_rvalid_i,
    input  logic [DATA_W-1:0] fu_result_i,
    output logic              wr_en_o,
    output logic              wr_scalar_o,
    output logic [LIDX_W-1:0] wr_lane_o,
    output logic [DATA_W-1:0] wr_data_o
);
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0000;
    localparam logic [3:0] OP_SUM = 4'b0011;
    localparam logic [3:0] OP_SET = 4'b0111;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [LIDX_W-1:0]   lane_q, lane_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_scalar_q, wr_scalar_d;
    logic [LIDX_W-1:0]   wr_lane_q, wr_lane_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic op_ok, accept, is_sum, last, got, issue;

    assign op_ok  = alucontrol_i == OP_ADD || alucontrol_i == OP_MUL ||
                    alucontrol_i == OP_SUM || alucontrol_i == OP_SET;
    assign accept = state_q == IDLE && start_i && op_ok;
    assign is_sum = op_q == OP_SUM;
    assign last   = lane_q == LIDX_W'(LANES - 1);
    assign got    = state_q == WAIT && fu_rvalid_i;
    assign issue  = state_q == ISSUE;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            op_q        <= '0;
            lane_q      <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_scalar_q <= 1'b0;
            wr_lane_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            wr_scalar_q <= wr_scalar_d;
            wr_lane_q   <= wr_lane_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = fu_ready_i ? WAIT : ISSUE;
            WAIT:    state_d = fu_rvalid_i ? (last ? FINISH : ISSUE) : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // vsum only writes once, on the last lane, to the scalar destination
    always_comb begin
        op_d        = accept ? alucontrol_i : op_q;
        lane_d      = accept ? '0 : (got && !last) ? lane_q + LIDX_W'(1) : lane_q;
        acc_d       = accept ? '0 : (got && is_sum) ? fu_result_i : acc_q;
        err_d       = state_q == IDLE && start_i && !op_ok;
        wr_en_d     = got && (!is_sum || last);
        wr_scalar_d = wr_en_d && is_sum;
        wr_lane_d   = (wr_en_d && !is_sum) ? lane_q : '0;
        wr_data_d   = wr_en_d ? fu_result_i : '0;
    end

    always_comb begin
        stall_o      = accept || issue || state_q == WAIT;
        busy_o       = state_q != IDLE;
        done_o       = state_q == FINISH || err_q;
        err_o        = err_q;
        fu_valid_o   = issue;
        fu_op_o      = issue ? op_q : '0;
        fu_lane_o    = issue ? lane_q : '0;
        fu_use_acc_o = issue && is_sum;
        acc_o        = acc_q;
        wr_en_o      = wr_en_q;
        wr_scalar_o  = wr_scalar_q;
        wr_lane_o    = wr_lane_q;
        wr_data_o    = wr_data_q;
    end
endmodule
